axis_ramp_pkt_checker: RTL and testbench
========================================

// Module: axis_ramp_pkt_checker
// PURPOSE
//   Synthesizable AXI-Stream sink that checks incoming ramp packets.
//   Each packet must be cfg_start + n*cfg_inc for word index n = 0,1,..., with tlast on the last word.
//   The block counts packets, data errors and length errors, and can apply pseudo-random backpressure.
//   It sits directly downstream of an AXI-Stream ramp source (DUT output or push_ramp_pkt stimulus).
//   Typical uses are loopback self-test and bench scoreboarding.
// PARAMETERS
//   DWIDTH     32  tdata width; ramp arithmetic is modulo 2^DWIDTH
//   PKT_LEN_W  16  width of cfg_pkt_len and of the in-packet word index
//   CNT_W      32  width of statistic counters (saturating)
// PORTS
//   clk            in   1          clock
//   reset          in   1          asynchronous, active-high reset
//   clear          in   1          sync clear of counters, sticky flag, error index and FSM
//   en             in   1          enable; 0 forces tready low
//   cfg_start      in   DWIDTH     ramp start value
//   cfg_inc        in   DWIDTH     ramp increment per word
//   cfg_pkt_len    in   PKT_LEN_W  expected words per packet; 0 disables the length check
//   cfg_throttle   in   1          1 = pseudo-random backpressure on tready
//   s_axis_tdata   in   DWIDTH     stream data
//   s_axis_tvalid  in   1          stream valid
//   s_axis_tlast   in   1          stream last (end of packet)
//   s_axis_tready  out  1          stream ready (registered)
//   pkt_count      out  CNT_W      packets received (beats with tlast)
//   err_data_count out  CNT_W      beats whose data mismatched the ramp
//   err_len_count  out  CNT_W      packets with wrong length
//   err_sticky     out  1          set on any error; cleared only by reset or clear
//   err_index      out  PKT_LEN_W  word index of the most recent data error
// BEHAVIOUR
//   - Reset values: all outputs 0. FSM = S_FIRST. LFSR = 16'h0001. Expected-value and index registers = 0.
//   - Beat = tvalid & tready on a rising edge of clk. Only beats advance state.
//   - tready (registered): next = en & (~cfg_throttle | lfsr[0]).
//     - The 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle when not in reset.
//     - tready never depends combinationally on tvalid.
//   - Config is latched into shadow registers on the first beat of each packet. Changes mid-packet are ignored until the next packet.
//   - Expected data: first beat compared to cfg_start. Each later beat compared to prev_expected + inc_latched (wraps mod 2^DWIDTH).
//   - Mismatch beat: err_data_count += 1, err_index <= word index, err_sticky <= 1.
//   - FSM states:
//     - S_FIRST (waiting for word 0), on a beat:
//       - tlast -> stay S_FIRST.
//       - else if len_latched == 1 -> S_OVER.
//       - else -> S_BODY.
//     - S_BODY, on a beat at index i:
//       - tlast -> S_FIRST.
//       - else if len_latched != 0 and i == len_latched-1 -> S_OVER.
//     - S_OVER (length reached, no tlast yet): stay until a tlast beat, then -> S_FIRST.
//   - Length errors, at most one per packet:
//     - Short: tlast at index < len_latched-1.
//     - Long: first beat in S_OVER.
//     - Each increments err_len_count and sets err_sticky.
//     - With len_latched == 0 no length errors are ever raised.
//   - Data checking continues in S_OVER: the ramp keeps incrementing.
//   - Single-word packet (tlast on word 0) with len 1: pkt_count += 1, no error.
//   - Every tlast beat: pkt_count += 1.
//   - Latency: all counters and flags update on the clock edge after the beat (1 cycle).
//   - Counters saturate at all-ones and never wrap.
//   - Word index saturates at all-ones in S_OVER.
//   - Simultaneous data and length error on one beat: both counters increment.
//   - clear coincident with a beat: clear wins, and the beat is not counted.
//   - reset mid-packet: everything returns to reset values immediately; the next beat is treated as word 0.
// TESTING
//   1. start=0x100, inc=1, len=8, clean 8-word ramp -> pkt_count=1, both err counts 0, err_sticky=0.
//   2. Same config, word 3 = 0xDEAD -> err_data_count=1, err_index=3, err_sticky=1, err_len_count=0.
//   3. len=8, 5-word packet then a clean 8-word packet -> err_len_count=1, pkt_count=2, err_data_count=0.
//   4. len=8, 10-word ramp, inc=0xFFFFFFFF, start=2 (wraps) -> err_len_count=1 (once), err_data_count=0.
//   5. cfg_throttle=1, 100-word packet, len=100 -> tready low on some cycles, no errors, pkt_count=1.
//   6. reset pulsed after word 4 of 8, then a clean 8-word packet -> counters read 0, then 1; no errors.

Source files
------------

// File: rtl/axis_ramp_pkt_checker.sv
// AXI-Stream sink that checks ramp packets (start + n*inc) and counts packets, data errors
// and length errors; optional LFSR-driven backpressure on tready.
module axis_ramp_pkt_checker #(
   parameter int DWIDTH    = 32,
   parameter int PKT_LEN_W = 16,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic [DWIDTH-1:0]    cfg_start,
   input  logic [DWIDTH-1:0]    cfg_inc,
   input  logic [PKT_LEN_W-1:0] cfg_pkt_len,
   input  logic                 cfg_throttle,
   input  logic [DWIDTH-1:0]    s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [CNT_W-1:0]     pkt_count,
   output logic [CNT_W-1:0]     err_data_count,
   output logic [CNT_W-1:0]     err_len_count,
   output logic                 err_sticky,
   output logic [PKT_LEN_W-1:0] err_index
);

   typedef enum logic [1:0] {
      S_FIRST = 2'd0,
      S_BODY  = 2'd1,
      S_OVER  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [15:0]          lfsr;
   logic                 lfsr_fb;
   logic [DWIDTH-1:0]    inc_latched;
   logic [DWIDTH-1:0]    exp_prev;
   logic [DWIDTH-1:0]    exp_cur;
   logic [PKT_LEN_W-1:0] len_latched;
   logic [PKT_LEN_W-1:0] len_cur;
   logic [PKT_LEN_W-1:0] idx;
   logic                 long_seen;
   logic                 beat;
   logic                 first;
   logic                 data_err;
   logic                 short_err;
   logic                 long_err;
   logic                 len_err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign beat    = s_axis_tvalid & s_axis_tready;
   assign first   = (state == S_FIRST);
   // On word 0 the shadow registers are being loaded, so use the live config directly.
   assign len_cur = first ? cfg_pkt_len : len_latched;
   assign exp_cur = first ? cfg_start : exp_prev + inc_latched;
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign len_err = short_err | long_err;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr          <= 16'h0001;
         s_axis_tready <= 1'b0;
      end else begin
         lfsr          <= {lfsr[14:0], lfsr_fb};
         s_axis_tready <= en & (~cfg_throttle | lfsr[0]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FIRST;
      end else if (clear) begin
         state <= S_FIRST;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      if (beat) begin
         unique case (state)
            S_FIRST: begin
               if (s_axis_tlast)                 state_next = S_FIRST;
               else if (len_cur == PKT_LEN_W'(1)) state_next = S_OVER;
               else                              state_next = S_BODY;
            end
            S_BODY: begin
               if (s_axis_tlast)
                  state_next = S_FIRST;
               else if (len_cur != '0 && idx == len_cur - PKT_LEN_W'(1))
                  state_next = S_OVER;
            end
            S_OVER: begin
               if (s_axis_tlast) state_next = S_FIRST;
            end
            default: state_next = S_FIRST;
         endcase
      end
   end

   always_comb begin
      data_err  = 1'b0;
      short_err = 1'b0;
      long_err  = 1'b0;
      if (beat) begin
         data_err = (s_axis_tdata != exp_cur);
         if (len_cur != '0) begin
            short_err = s_axis_tlast && (state != S_OVER) && (idx < len_cur - PKT_LEN_W'(1));
            long_err  = (state == S_OVER) && !long_seen;
         end
      end
   end

   // NOTE: shadow config and expected-value registers are reset too, keeping the post-reset state fully defined.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_latched    <= '0;
         len_latched    <= '0;
         exp_prev       <= '0;
         idx            <= '0;
         long_seen      <= 1'b0;
         pkt_count      <= '0;
         err_data_count <= '0;
         err_len_count  <= '0;
         err_sticky     <= 1'b0;
         err_index      <= '0;
      end else if (clear) begin
         idx            <= '0;
         long_seen      <= 1'b0;
         pkt_count      <= '0;
         err_data_count <= '0;
         err_len_count  <= '0;
         err_sticky     <= 1'b0;
         err_index      <= '0;
      end else if (beat) begin
         if (first) begin
            inc_latched <= cfg_inc;
            len_latched <= cfg_pkt_len;
         end
         exp_prev <= exp_cur;
         if (s_axis_tlast) begin
            idx       <= '0;
            long_seen <= 1'b0;
            pkt_count <= sat_inc(pkt_count);
         end else begin
            idx       <= (idx == '1) ? idx : idx + PKT_LEN_W'(1);
            long_seen <= long_seen | long_err;
         end
         if (data_err) begin
            err_data_count <= sat_inc(err_data_count);
            err_index      <= idx;
         end
         if (len_err) begin
            err_len_count <= sat_inc(err_len_count);
         end
         if (data_err || len_err) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_ramp_pkt_checker.sv
// Randomized bench for axis_ramp_pkt_checker: a packet-level model (expected = start + n*inc)
// is compared against the DUT every cycle, plus literal checks for the directed scenarios.
module tb_axis_ramp_pkt_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        en = 1'b0;
   logic [31:0] cfg_start = '0;
   logic [31:0] cfg_inc = '0;
   logic [15:0] cfg_pkt_len = '0;
   logic        cfg_throttle = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [31:0] pkt_count;
   logic [31:0] err_data_count;
   logic [31:0] err_len_count;
   logic        err_sticky;
   logic [15:0] err_index;

   int n_checks = 0;
   int n_errors = 0;
   int low_cycles = 0;

   always #5 clk = ~clk;

   axis_ramp_pkt_checker dut (
      .clk(clk), .reset(reset), .clear(clear), .en(en),
      .cfg_start(cfg_start), .cfg_inc(cfg_inc), .cfg_pkt_len(cfg_pkt_len),
      .cfg_throttle(cfg_throttle),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .pkt_count(pkt_count), .err_data_count(err_data_count), .err_len_count(err_len_count),
      .err_sticky(err_sticky), .err_index(err_index)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Behavioural model: packet word counter n, expected data start + n*inc.
   logic [31:0] m_start = '0, m_inc = '0;
   int          m_len = 0;
   int          m_n = 0;
   logic [31:0] m_pkt = '0, m_derr = '0, m_lerr = '0;
   logic        m_sticky = 1'b0;
   logic [15:0] m_eidx = '0;
   logic [15:0] m_lfsr = 16'h0001;
   logic        m_tready = 1'b0;
   logic [31:0] m_expd;

   always @(posedge clk) begin
      if (reset) begin
         m_start = '0; m_inc = '0; m_len = 0; m_n = 0;
         m_pkt = '0; m_derr = '0; m_lerr = '0; m_sticky = 1'b0; m_eidx = '0;
         m_lfsr = 16'h0001; m_tready = 1'b0;
      end else begin
         if (clear) begin
            m_pkt = '0; m_derr = '0; m_lerr = '0; m_sticky = 1'b0; m_eidx = '0; m_n = 0;
         end else if (s_axis_tvalid && s_axis_tready) begin
            if (m_n == 0) begin
               m_start = cfg_start; m_inc = cfg_inc; m_len = int'(cfg_pkt_len);
            end
            m_expd = m_start + m_inc * 32'(m_n);
            if (s_axis_tdata != m_expd) begin
               m_derr = sat32(m_derr);
               m_eidx = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
               m_sticky = 1'b1;
            end
            if (m_len != 0 && ((s_axis_tlast && m_n < m_len - 1) || m_n == m_len)) begin
               m_lerr = sat32(m_lerr);
               m_sticky = 1'b1;
            end
            if (s_axis_tlast) begin
               m_pkt = sat32(m_pkt);
               m_n = 0;
            end else begin
               m_n++;
            end
         end
         m_tready = en && (!cfg_throttle || m_lfsr[0]);
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("tready", s_axis_tready, m_tready);
         check("pkt_count", pkt_count, m_pkt);
         check("err_data_count", err_data_count, m_derr);
         check("err_len_count", err_len_count, m_lerr);
         check("err_sticky", err_sticky, m_sticky);
         check("err_index", err_index, m_eidx);
         if (en && cfg_throttle && !s_axis_tready) low_cycles++;
      end
   end

   task automatic send_pkt(input logic [31:0] start, input logic [31:0] inc, input logic [15:0] len,
                           input int nwords, input int bad_idx, input logic [31:0] bad_val,
                           input bit scramble, input bit gaps, input bit with_last);
      int  k = 0;
      int  guard = 0;
      bit  pres = 0;
      bit  scrambled = 0;
      @(negedge clk);
      cfg_start = start; cfg_inc = inc; cfg_pkt_len = len;
      while (k < nwords) begin
         if (guard > 0) @(negedge clk);
         guard++;
         if (guard > 3000) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: sent %0d words, required %0d", k, nwords);
            break;
         end
         if (scramble && k == 1 && !scrambled) begin
            cfg_start = $urandom; cfg_inc = $urandom; cfg_pkt_len = 16'($urandom_range(9));
            scrambled = 1;
         end
         if (!pres && gaps && $urandom_range(3) == 0) begin
            s_axis_tvalid = 1'b0;
         end else begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = (k == bad_idx) ? bad_val : start + inc * 32'(k);
            s_axis_tlast = with_last && (k == nwords - 1);
            pres = 1;
            if (s_axis_tready) begin
               k++;
               pres = 0;
            end
         end
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nw, bad;
      logic [31:0] st, ic;
      logic [15:0] ln;

      idle(3);
      check("rst_tready", s_axis_tready, 0);
      check("rst_pkt", pkt_count, 0);
      check("rst_derr", err_data_count, 0);
      check("rst_lerr", err_len_count, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_eidx", err_index, 0);
      reset = 1'b0;
      en = 1'b1;
      idle(2);

      // 1: clean ramp
      pulse_clear();
      send_pkt(32'h100, 32'd1, 16'd8, 8, -1, 0, 0, 1, 1);
      idle(2);
      check("t1_pkt", pkt_count, 1);
      check("t1_derr", err_data_count, 0);
      check("t1_lerr", err_len_count, 0);
      check("t1_sticky", err_sticky, 0);

      // 2: corrupted word 3
      pulse_clear();
      send_pkt(32'h100, 32'd1, 16'd8, 8, 3, 32'hDEAD, 0, 1, 1);
      idle(2);
      check("t2_derr", err_data_count, 1);
      check("t2_eidx", err_index, 3);
      check("t2_sticky", err_sticky, 1);
      check("t2_lerr", err_len_count, 0);

      // 3: short packet then clean packet
      pulse_clear();
      send_pkt(32'h100, 32'd1, 16'd8, 5, -1, 0, 0, 1, 1);
      send_pkt(32'h100, 32'd1, 16'd8, 8, -1, 0, 0, 1, 1);
      idle(2);
      check("t3_lerr", err_len_count, 1);
      check("t3_pkt", pkt_count, 2);
      check("t3_derr", err_data_count, 0);

      // 4: long packet with wrapping ramp
      pulse_clear();
      send_pkt(32'd2, 32'hFFFF_FFFF, 16'd8, 10, -1, 0, 0, 1, 1);
      idle(2);
      check("t4_lerr", err_len_count, 1);
      check("t4_derr", err_data_count, 0);
      check("t4_pkt", pkt_count, 1);

      // 5: throttled 100-word packet
      pulse_clear();
      low_cycles = 0;
      cfg_throttle = 1'b1;
      send_pkt(32'h1234_0000, 32'd7, 16'd100, 100, -1, 0, 0, 0, 1);
      cfg_throttle = 1'b0;
      idle(3);
      check("t5_tready_low_seen", (low_cycles > 0), 1);
      check("t5_pkt", pkt_count, 1);
      check("t5_derr", err_data_count, 0);
      check("t5_lerr", err_len_count, 0);

      // single-word packet with len 1
      send_pkt(32'h55, 32'd3, 16'd1, 1, -1, 0, 0, 0, 1);
      idle(2);
      check("single_pkt", pkt_count, 2);
      check("single_lerr", err_len_count, 0);

      // en low forces tready low
      en = 1'b0;
      idle(3);
      check("en_low_tready", s_axis_tready, 0);
      en = 1'b1;
      idle(3);

      // clear coincident with a beat: the beat is not counted
      @(negedge clk);
      check("clr_beat_tready_ready", s_axis_tready, 1);
      cfg_start = 32'h10; cfg_inc = 32'd1; cfg_pkt_len = 16'd1;
      s_axis_tdata = 32'h10; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; clear = 1'b1;
      @(negedge clk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clear = 1'b0;
      check("clr_beat_pkt", pkt_count, 0);

      // randomized packets against the model
      for (int p = 0; p < 60; p++) begin
         nw = int'($urandom_range(14, 1));
         st = $urandom;
         ic = $urandom_range(1) ? $urandom : 32'($urandom_range(3));
         ln = 16'($urandom_range(10));
         bad = ($urandom_range(3) == 0) ? int'($urandom_range(nw - 1)) : -1;
         cfg_throttle = ($urandom_range(2) == 0);
         send_pkt(st, ic, ln, nw, bad, st ^ ($urandom | 32'h1) ^ (ic * 32'(bad)),
                  ($urandom_range(1) == 1), 1, 1);
         if ($urandom_range(9) == 0) pulse_clear();
      end
      cfg_throttle = 1'b0;
      idle(3);

      // 6: reset mid-packet, then a clean packet
      send_pkt(32'h100, 32'd1, 16'd8, 4, -1, 0, 0, 0, 0);
      @(negedge clk); reset = 1'b1;
      idle(2);
      check("t6_rst_pkt", pkt_count, 0);
      check("t6_rst_derr", err_data_count, 0);
      check("t6_rst_lerr", err_len_count, 0);
      check("t6_rst_tready", s_axis_tready, 0);
      reset = 1'b0;
      idle(2);
      send_pkt(32'h100, 32'd1, 16'd8, 8, -1, 0, 0, 1, 1);
      idle(2);
      check("t6_pkt", pkt_count, 1);
      check("t6_derr", err_data_count, 0);
      check("t6_lerr", err_len_count, 0);
      check("t6_sticky", err_sticky, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
